// File: rtl/load_store_unit.sv
// Purpose : single-outstanding LOAD/STORE engine between decode and the data bus.
// Latency : accept cycle 0, bus_valid cycle 1; zero-wait load writes back cycle 2, idle cycle 3.
// Backpr. : req_ready only in IDLE; bus_ready stalls BUS (optional timeout -> fault).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      decode handshake; req_store/req_byte/req_signed/req_addr/req_reg
//   rf_index, rf_store       register-file memory port read (rf_store combinational on rf_index)
//   rf_load, rf_load_en      register-file write, one-cycle strobe
//   bus_valid/bus_ready      data bus handshake; bus_we/bus_addr/bus_wdata/bus_wstrb, bus_rdata
//   busy, fault              status; fault is a one-cycle pulse
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_reg,
  output logic [3:0]  rf_index,
  input  logic [15:0] rf_store,
  output logic [15:0] rf_load,
  output logic        rf_load_en,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic [1:0]  bus_wstrb,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        fault
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB, S_FAULT} state_t;

  // Only the fields needed after accept; the bus address is registered directly.
  typedef struct packed {
    logic       store;
    logic       byte_acc;
    logic       sgn;
    logic       lsb;
    logic [3:0] rd;
  } req_t;

  state_t        state;
  req_t          req_q;
  logic [CW-1:0] cnt;

  logic [7:0]  rd_byte;
  logic [15:0] load_fmt;
  logic [15:0] store_dat;
  logic [15:0] store_bus;
  logic [1:0]  store_strb;

  always_comb begin
    rd_byte    = req_q.lsb ? bus_rdata[15:8] : bus_rdata[7:0];
    load_fmt   = bus_rdata;
    if (req_q.byte_acc)
      load_fmt = {(req_q.sgn ? {8{rd_byte[7]}} : 8'h00), rd_byte};
    // r0 is hardwired zero regardless of what the register file returns.
    store_dat  = (req_reg == 4'd0) ? 16'h0000 : rf_store;
    store_bus  = req_byte ? {2{store_dat[7:0]}} : store_dat;
    store_strb = 2'b00;
    if (req_store)
      store_strb = req_byte ? (req_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  end

  // Gated by rst so the address output reads zero during reset even though IDLE muxes req_reg.
  assign rf_index = rst ? 4'd0 : ((state == S_IDLE) ? req_reg : req_q.rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_q      <= '0;
      cnt        <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 16'h0000;
      bus_wdata  <= 16'h0000;
      bus_wstrb  <= 2'b00;
      rf_load    <= 16'h0000;
      rf_load_en <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          fault      <= 1'b0;
          rf_load_en <= 1'b0;
          if (req_valid && req_ready) begin
            req_q     <= '{store: req_store, byte_acc: req_byte, sgn: req_signed,
                           lsb: req_addr[0], rd: req_reg};
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (!req_byte && req_addr[0]) begin
              state <= S_FAULT;
              fault <= 1'b1;
            end else begin
              state     <= S_BUS;
              bus_valid <= 1'b1;
              bus_we    <= req_store;
              bus_addr  <= {req_addr[15:1], 1'b0};
              bus_wdata <= store_bus;
              bus_wstrb <= store_strb;
            end
          end
        end

        S_BUS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (req_q.store) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state      <= S_WB;
              rf_load    <= load_fmt;
              // Loads to r0 still read the bus but never write back.
              rf_load_en <= (req_q.rd != 4'd0);
            end
          end else if (TO_EN && cnt == CNT_LAST) begin
            // Timeout reuses the FAULT state for its one-cycle pulse.
            bus_valid <= 1'b0;
            fault     <= 1'b1;
            state     <= S_FAULT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_WB: begin
          rf_load_en <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        S_FAULT: begin
          fault     <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : directed table-driven bench for load_store_unit plus multi-cycle corner sequences.
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : bus_ready driven by the bench per vector/sequence.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_byte, req_signed;
  logic [15:0] req_addr;
  logic [3:0]  req_reg, rf_index;
  logic [15:0] rf_store, rf_load;
  logic        rf_load_en;
  logic        bus_valid, bus_ready, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_wstrb;
  logic        busy, fault;

  logic [15:0] rf [16];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_store = rf[rf_index];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr), .req_reg(req_reg),
    .rf_index(rf_index), .rf_store(rf_store), .rf_load(rf_load), .rf_load_en(rf_load_en),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .busy(busy), .fault(fault)
  );

  typedef struct {
    logic        store;
    logic        byte_acc;
    logic        sgn;
    logic [15:0] addr;
    logic [3:0]  rd;
    logic [15:0] rfv;
    logic [15:0] rdata;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_wstrb;
    logic [15:0] e_load;
    logic        e_en;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic by, input logic sg,
                           input logic [15:0] a, input logic [3:0] r);
    req_valid  = 1'b1;
    req_store  = st;
    req_byte   = by;
    req_signed = sg;
    req_addr   = a;
    req_reg    = r;
  endtask

  // Zero-wait access; called at posedge+1 with the LSU idle.
  task automatic do_access(input int i, input vec_t v);
    if (v.store) rf[v.rd] = v.rfv;
    bus_ready = 1'b1;
    bus_rdata = v.rdata;
    drive_req(v.store, v.byte_acc, v.sgn, v.addr, v.rd);
    @(negedge clk);
    check($sformatf("v%0d_c0_ready", i), 16'(req_ready), 16'h1);
    check($sformatf("v%0d_c0_index", i), 16'(rf_index), 16'(v.rd));
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_c1_valid", i), 16'(bus_valid), 16'h1);
    check($sformatf("v%0d_c1_addr", i), bus_addr, v.e_addr);
    check($sformatf("v%0d_c1_we", i), 16'(bus_we), 16'(v.store));
    check($sformatf("v%0d_c1_wstrb", i), 16'(bus_wstrb), 16'(v.e_wstrb));
    if (v.store) check($sformatf("v%0d_c1_wdata", i), bus_wdata, v.e_wdata);
    step();
    @(negedge clk);
    check($sformatf("v%0d_c2_valid", i), 16'(bus_valid), 16'h0);
    if (v.store) begin
      check($sformatf("v%0d_c2_ready", i), 16'(req_ready), 16'h1);
      check($sformatf("v%0d_c2_busy", i), 16'(busy), 16'h0);
      step();
    end else begin
      check($sformatf("v%0d_c2_load_en", i), 16'(rf_load_en), 16'(v.e_en));
      check($sformatf("v%0d_c2_index", i), 16'(rf_index), 16'(v.rd));
      if (v.e_en) check($sformatf("v%0d_c2_load", i), rf_load, v.e_load);
      step();
      @(negedge clk);
      check($sformatf("v%0d_c3_ready", i), 16'(req_ready), 16'h1);
      check($sformatf("v%0d_c3_load_en", i), 16'(rf_load_en), 16'h0);
      step();
    end
  endtask

  initial begin
    int hi_cycles;
    for (int r = 0; r < 16; r++) rf[r] = 16'h1000 + 16'(r);
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0000; req_reg = 4'd9; bus_ready = 1'b0; bus_rdata = 16'h0000;

    //                store byte sgn  addr      rd    rfv       rdata     e_addr    e_wdata   strb   e_load    en
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 4'd3, 16'h0000, 16'hBEEF, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0021, 4'd2, 16'h0000, 16'h80FF, 16'h0020, 16'h0000, 2'b00, 16'hFF80, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0021, 4'd2, 16'h0000, 16'h80FF, 16'h0020, 16'h0000, 2'b00, 16'h0080, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0030, 4'd4, 16'h0000, 16'h12F0, 16'h0030, 16'h0000, 2'b00, 16'hFFF0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0100, 4'd7, 16'hA55A, 16'h0000, 16'h0100, 16'hA55A, 2'b11, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0040, 4'd5, 16'h1234, 16'h0000, 16'h0040, 16'h3434, 2'b01, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0200, 4'd0, 16'hFFFF, 16'h0000, 16'h0200, 16'h0000, 2'b11, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0050, 4'd0, 16'h0000, 16'h1111, 16'h0050, 16'h0000, 2'b00, 16'h0000, 1'b0};

    // Reset state
    #2;
    check("rst_ready", 16'(req_ready), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_valid", 16'(bus_valid), 16'h0);
    check("rst_fault", 16'(fault), 16'h0);
    check("rst_load_en", 16'(rf_load_en), 16'h0);
    check("rst_index", 16'(rf_index), 16'h0);
    check("rst_addr", bus_addr, 16'h0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) do_access(i, vecs[i]);

    // Byte store with bus_ready held off for 3 cycles: controls must stay stable.
    rf[5] = 16'h1234;
    bus_ready = 1'b0;
    drive_req(1'b1, 1'b1, 1'b0, 16'h0041, 4'd5);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus_ready = 1'b1;
      @(negedge clk);
      check($sformatf("st_c%0d_valid", c), 16'(bus_valid), 16'h1);
      check($sformatf("st_c%0d_addr", c), bus_addr, 16'h0040);
      check($sformatf("st_c%0d_wdata", c), bus_wdata, 16'h3434);
      check($sformatf("st_c%0d_wstrb", c), 16'(bus_wstrb), 16'h2);
      check($sformatf("st_c%0d_we", c), 16'(bus_we), 16'h1);
      step();
    end
    bus_ready = 1'b0;
    @(negedge clk);
    check("st_done_valid", 16'(bus_valid), 16'h0);
    check("st_done_ready", 16'(req_ready), 16'h1);
    step();

    // Misaligned word load
    drive_req(1'b0, 1'b0, 1'b0, 16'h0003, 4'd6);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("mis_c1_fault", 16'(fault), 16'h1);
    check("mis_c1_valid", 16'(bus_valid), 16'h0);
    check("mis_c1_load_en", 16'(rf_load_en), 16'h0);
    step();
    @(negedge clk);
    check("mis_c2_fault", 16'(fault), 16'h0);
    check("mis_c2_valid", 16'(bus_valid), 16'h0);
    check("mis_c2_load_en", 16'(rf_load_en), 16'h0);
    check("mis_c2_ready", 16'(req_ready), 16'h1);
    step();

    // Timeout with bus_ready stuck low (TIMEOUT_CYCLES = 4)
    bus_ready = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 16'h0060, 4'd8);
    step();
    req_valid = 1'b0;
    hi_cycles = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus_valid) hi_cycles++;
      check($sformatf("to_c%0d_fault", c), 16'(fault), 16'h0);
      step();
    end
    check("to_valid_cycles", 16'(hi_cycles), 16'd4);
    @(negedge clk);
    check("to_c5_valid", 16'(bus_valid), 16'h0);
    check("to_c5_fault", 16'(fault), 16'h1);
    check("to_c5_load_en", 16'(rf_load_en), 16'h0);
    step();
    @(negedge clk);
    check("to_c6_fault", 16'(fault), 16'h0);
    check("to_c6_ready", 16'(req_ready), 16'h1);
    check("to_c6_busy", 16'(busy), 16'h0);
    step();

    // Reset in the middle of BUS: bus_valid must fall without a clock edge.
    drive_req(1'b0, 1'b0, 1'b0, 16'h0070, 4'd9);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("rb_c1_valid", 16'(bus_valid), 16'h1);
    step();
    rst = 1'b1;
    #1;
    check("rb_valid_async", 16'(bus_valid), 16'h0);
    check("rb_busy", 16'(busy), 16'h0);
    check("rb_ready", 16'(req_ready), 16'h0);
    check("rb_fault", 16'(fault), 16'h0);
    check("rb_addr", bus_addr, 16'h0);
    step();
    check("rb_load_en", 16'(rf_load_en), 16'h0);
    rst = 1'b0;
    step();
    do_access(8, vecs[7]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
